des_fround_pipe: RTL and testbench

- Two-stage pipelined DES Feistel round stage, built around the eight S-box lookups.
- Stage 1 performs E-expansion of R and XOR with the 48-bit round subkey, then registers the result.
- Stage 2 performs the S-box substitution, the P permutation and the XOR with L, then applies the Feistel swap and registers the result.
- Sits between the key-schedule/round controller (upstream) and the round-result register / next round (downstream), with valid/ready handshakes on both sides.

---
 rtl/des_pkg.sv | 100 ++++++++++
 rtl/des_fround_pipe_if.sv | 26 ++
 rtl/des_sbox_bank.sv | 19 +
 rtl/des_fround_pipe.sv | 104 ++++++++++
 tb/tb_des_fround_pipe.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/des_pkg.sv
// des_pkg: DES round constants (E expansion, P permutation, S-boxes) and the
// bit-permutation helpers shared by the Feistel round stage.
// Bit order: DES bit 1 is the MSB of every vector (hex literals read MSB-first
// in DES notation), so DES bit n lives at index W-n.
package des_pkg;

  localparam int NUM_SBOX = 8;
  localparam int HALF_W   = 32;
  localparam int KEY_W    = 6 * NUM_SBOX;

  typedef logic [HALF_W-1:0] half_t;
  typedef logic [KEY_W-1:0]  key_t;

  // raw round input as presented upstream
  typedef struct packed {
    half_t l;
    half_t r;
    key_t  k;
    logic  last;
  } fr_in_t;

  // stage-1 payload: halves plus keyed expansion
  typedef struct packed {
    half_t l;
    half_t r;
    key_t  x;
    logic  last;
  } fr_s1_t;

  // round result
  typedef struct packed {
    half_t l;
    half_t r;
  } fr_out_t;

  localparam int E_TAB [KEY_W] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1
  };

  localparam int P_TAB [HALF_W] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  // [box][row][col], box 0 = S1
  localparam int SBOX [NUM_SBOX][4][16] = '{
    '{'{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7},
      '{ 0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8},
      '{ 4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0},
      '{15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13}},
    '{'{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10},
      '{ 3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5},
      '{ 0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15},
      '{13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9}},
    '{'{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8},
      '{13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1},
      '{13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7},
      '{ 1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12}},
    '{'{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15},
      '{13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9},
      '{10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4},
      '{ 3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14}},
    '{'{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9},
      '{14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6},
      '{ 4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14},
      '{11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3}},
    '{'{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11},
      '{10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8},
      '{ 9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6},
      '{ 4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13}},
    '{'{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1},
      '{13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6},
      '{ 1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2},
      '{ 6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12}},
    '{'{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7},
      '{ 1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2},
      '{ 7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8},
      '{ 2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}}
  };

  // E expansion: output bit i (DES order) takes R bit E_TAB[i]
  function automatic key_t des_expand(input half_t r);
    key_t e;
    for (int i = 0; i < KEY_W; i++) e[KEY_W-1-i] = r[HALF_W-E_TAB[i]];
    return e;
  endfunction

  // P permutation on the concatenated S-box outputs
  function automatic half_t des_perm_p(input half_t s);
    half_t p;
    for (int i = 0; i < HALF_W; i++) p[HALF_W-1-i] = s[HALF_W-P_TAB[i]];
    return p;
  endfunction

endpackage

// File: rtl/des_fround_pipe_if.sv
// des_fround_pipe_if: upstream and downstream valid/ready channels of the
// DES round stage. master = round controller / result sink side, slave = stage.
interface des_fround_pipe_if;
  import des_pkg::*;

  logic  in_valid;
  logic  in_ready;
  half_t in_l;
  half_t in_r;
  key_t  in_k;
  logic  in_last;
  logic  out_valid;
  logic  out_ready;
  half_t out_l;
  half_t out_r;

  modport master (
    output in_valid, in_l, in_r, in_k, in_last, out_ready,
    input  in_ready, out_valid, out_l, out_r
  );

  modport slave (
    input  in_valid, in_l, in_r, in_k, in_last, out_ready,
    output in_ready, out_valid, out_l, out_r
  );
endinterface

// File: rtl/des_sbox_bank.sv
// des_sbox_bank: combinational 48->32 lookup through all eight DES S-boxes.
// Box g consumes 6 bits starting at DES bit 6g+1; its 4-bit result lands at
// DES bits 4g+1..4g+4 (S1 in the top nibble).
module des_sbox_bank
  import des_pkg::*;
(
  input  key_t  x_i,
  output half_t y_o
);
  for (genvar g = 0; g < NUM_SBOX; g++) begin : g_box
    logic [5:0] b;
    logic [1:0] row;
    logic [3:0] col;
    assign b   = x_i[KEY_W-1-6*g -: 6];
    assign row = {b[5], b[0]};   // outer bits (DES b0, b5)
    assign col = b[4:1];         // inner bits (DES b1..b4)
    assign y_o[HALF_W-1-4*g -: 4] = 4'(SBOX[g][row][col]);
  end
endmodule

// File: rtl/des_fround_pipe.sv
// des_fround_pipe: two-stage pipelined DES Feistel round.
//   stage 1: E(R) ^ K registered with L, R, last
//   stage 2: S-boxes, P, XOR with L, Feistel swap (suppressed on last round)
// Optional macro DES_FROUND_SKID_EN adds a 1-entry input skid buffer so that
// in_ready is a flop and has no combinational path from out_ready.
module des_fround_pipe
  import des_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  des_fround_pipe_if.slave bus
);
  localparam int STAGES = 2;

  logic [STAGES:1] vld_pipe_q;
  fr_s1_t          s1_q, s1_d;
  fr_out_t         s2_q, s2_d;
  fr_in_t          in_beat, s1_src;
  logic            s1_adv, s2_adv, in_xfer, s1_fill;
  half_t           sbox_out, f;

  // a stage moves when its slot is empty or the stage after it moves
  assign s2_adv  = !vld_pipe_q[2] || bus.out_ready;
  assign s1_adv  = !vld_pipe_q[1] || s2_adv;
  assign in_beat = '{l: bus.in_l, r: bus.in_r, k: bus.in_k, last: bus.in_last};

`ifdef DES_FROUND_SKID_EN
  logic   skid_vld_q;
  logic   in_ready_q;
  fr_in_t skid_q;

  assign bus.in_ready = in_ready_q;
  assign in_xfer      = bus.in_valid && in_ready_q;
  // a buffered beat is older than anything on the bus, so it feeds stage 1 first
  assign s1_fill      = skid_vld_q || in_xfer;
  assign s1_src       = skid_vld_q ? skid_q : in_beat;

  // skid buffer: catch a beat accepted while stage 1 is stalled, drain it on the next advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_vld_q <= 1'b0;
      in_ready_q <= 1'b1;
      skid_q     <= '0;
    end else if (skid_vld_q) begin
      if (s1_adv) begin
        skid_vld_q <= 1'b0;
        in_ready_q <= 1'b1;
      end
    end else if (in_xfer && !s1_adv) begin
      skid_vld_q <= 1'b1;
      in_ready_q <= 1'b0;
      skid_q     <= in_beat;
    end
  end
`else
  assign bus.in_ready = s1_adv;
  assign in_xfer      = bus.in_valid && s1_adv;
  assign s1_fill      = in_xfer;
  assign s1_src       = in_beat;
`endif

  assign s1_d = '{l: s1_src.l, r: s1_src.r, x: des_expand(s1_src.r) ^ s1_src.k,
                  last: s1_src.last};

  des_sbox_bank u_sbox (
    .x_i (s1_q.x),
    .y_o (sbox_out)
  );

  assign f = des_perm_p(sbox_out);

  // Feistel swap, skipped on the final round
  always_comb begin
    s2_d = '{l: s1_q.r, r: s1_q.l ^ f};
    if (s1_q.last) s2_d = '{l: s1_q.l ^ f, r: s1_q.r};
  end

  // valid bits: each stage takes its predecessor's valid when it advances
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
    end else begin
      if (s1_adv) vld_pipe_q[1] <= s1_fill;
      if (s2_adv) vld_pipe_q[2] <= vld_pipe_q[1];
    end
  end

  // stage-1 data: only loaded by a real beat, bubbles keep old contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                s1_q <= '0;
    else if (s1_adv && s1_fill) s1_q <= s1_d;
  end

  // stage-2 data: held while out_valid is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      s2_q <= '0;
    else if (s2_adv && vld_pipe_q[1]) s2_q <= s2_d;
  end

  assign bus.out_valid = vld_pipe_q[2];
  assign bus.out_l     = s2_q.l;
  assign bus.out_r     = s2_q.r;

endmodule

// File: tb/tb_des_fround_pipe.sv
// tb_des_fround_pipe: directed and random checks of the pipelined DES round.
// Build with +define+DES_FROUND_SKID_EN to exercise the skid-buffer variant.
module tb_des_fround_pipe;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  des_fround_pipe_if bus ();

  des_fround_pipe dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef DES_FROUND_SKID_EN
  localparam int STALL_ACCEPTS = 3;
`else
  localparam int STALL_ACCEPTS = 2;
`endif
  localparam int N_RAND = 10000;

  typedef struct packed { logic [31:0] l; logic [31:0] r; } beat_t;
  beat_t exp_q[$];

  // reference model tables (box rows flattened: index = row*16 + col)
  localparam int P_REF [32] = '{16, 7,20,21,29,12,28,17, 1,15,23,26, 5,18,31,10,
                                 2, 8,24,14,32,27, 3, 9,19,13,30, 6,22,11, 4,25};
  localparam int S_REF [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  // f-function: expansion computed arithmetically (box j reads R bits 4j-1..4j+4 mod 32)
  function automatic logic [31:0] ref_f(input logic [31:0] r, input logic [47:0] k);
    logic [31:0] s, p;
    logic [5:0]  six;
    int          pos, v;
    s = '0;
    for (int j = 0; j < 8; j++) begin
      for (int m = 0; m < 6; m++) begin
        pos = (4*j + m + 31) % 32;
        six[5-m] = r[31-pos] ^ k[47-(6*j+m)];
      end
      v = S_REF[j][32*six[5] + 16*six[0] + int'(six[4:1])];
      s[31-4*j -: 4] = v[3:0];
    end
    for (int i = 0; i < 32; i++) p[31-i] = s[32-P_REF[i]];
    return p;
  endfunction

  function automatic beat_t ref_round(input logic [31:0] l, input logic [31:0] r,
                                      input logic [47:0] k, input logic last);
    logic [31:0] f;
    beat_t       b;
    f = ref_f(r, k);
    if (last) begin b.l = l ^ f; b.r = r;     end
    else      begin b.l = r;     b.r = l ^ f; end
    return b;
  endfunction

  task automatic drive(input logic v, input logic [31:0] l, input logic [31:0] r,
                       input logic [47:0] k, input logic last);
    bus.in_valid = v;
    bus.in_l     = l;
    bus.in_r     = r;
    bus.in_k     = k;
    bus.in_last  = last;
  endtask

  // deterministic vector generator for streaming/stall tests
  task automatic vec(input int i, output logic [31:0] l, output logic [31:0] r,
                     output logic [47:0] k, output logic last);
    l    = 32'h0123_4567 + 32'(i) * 32'h1357_9BDF;
    r    = 32'h89AB_CDEF ^ (32'(i) * 32'h0F0F_1234);
    k    = 48'h1B02_EFFC_7072 + 48'(i) * 48'h0000_1234_5677;
    last = (i % 4 == 3);
  endtask

  // one beat through an empty pipe; returns the cycle count to out_valid
  task automatic run_single(input logic [31:0] l, input logic [31:0] r, input logic [47:0] k,
                            input logic last, output logic [31:0] got_l,
                            output logic [31:0] got_r, output int lat);
    bus.out_ready = 1'b1;
    drive(1'b1, l, r, k, last);
    @(negedge clk);
    drive(1'b0, '0, '0, '0, 1'b0);
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    got_l = bus.out_l;
    got_r = bus.out_r;
    if (!bus.out_valid) lat = -1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_l !== 32'h0) begin errors++; $display("FAIL reset_out_l: got %h expected 00000000", bus.out_l); end
    checks++; if (bus.out_r !== 32'h0) begin errors++; $display("FAIL reset_out_r: got %h expected 00000000", bus.out_r); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_round1;
    logic [31:0] gl, gr;
    int          lat;
    run_single(32'hCC00_CCFF, 32'hF0AA_F0AA, 48'h1B02_EFFC_7072, 1'b0, gl, gr, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL round1_latency: got %0d expected 2", lat); end
    checks++; if (gl !== 32'hF0AA_F0AA) begin errors++; $display("FAIL round1_out_l: got %h expected f0aaf0aa", gl); end
    checks++; if (gr !== 32'hEF4A_6544) begin errors++; $display("FAIL round1_out_r: got %h expected ef4a6544", gr); end
  endtask

  task automatic test_zero;
    logic [31:0] gl, gr;
    int          lat;
    run_single('0, '0, '0, 1'b0, gl, gr, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL zero_latency: got %0d expected 2", lat); end
    checks++; if (gl !== 32'h0) begin errors++; $display("FAIL zero_out_l: got %h expected 00000000", gl); end
    checks++; if (gr !== 32'hD8D8_DBBC) begin errors++; $display("FAIL zero_out_r: got %h expected d8d8dbbc", gr); end
    run_single('0, '0, '0, 1'b1, gl, gr, lat);
    checks++; if (gl !== 32'hD8D8_DBBC) begin errors++; $display("FAIL zero_last_out_l: got %h expected d8d8dbbc", gl); end
    checks++; if (gr !== 32'h0) begin errors++; $display("FAIL zero_last_out_r: got %h expected 00000000", gr); end
  endtask

  task automatic test_back_to_back;
    int          n_in, n_out, cyc;
    logic [31:0] l, r;
    logic [47:0] k;
    logic        last;
    beat_t       e;
    n_in = 0; n_out = 0; cyc = 0;
    exp_q.delete();
    bus.out_ready = 1'b1;
    while (n_out < 8 && cyc < 50) begin
      if (n_in < 8) begin vec(n_in, l, r, k, last); drive(1'b1, l, r, k, last); end
      else drive(1'b0, '0, '0, '0, 1'b0);
      #1;
      if (cyc < 10) begin
        checks++;
        if (bus.out_valid !== (cyc >= 2)) begin
          errors++; $display("FAIL stream_valid_c%0d: got %b expected %b", cyc, bus.out_valid, cyc >= 2);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_round(bus.in_l, bus.in_r, bus.in_k, bus.in_last));
        n_in++;
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stream_extra: got %h%h expected no beat", bus.out_l, bus.out_r);
        end else begin
          e = exp_q.pop_front();
          if ({bus.out_l, bus.out_r} !== e) begin
            errors++; $display("FAIL stream_beat%0d: got %h expected %h", n_out, {bus.out_l, bus.out_r}, e);
          end
        end
        n_out++;
      end
      @(negedge clk);
      cyc++;
    end
    checks++; if (n_out != 8) begin errors++; $display("FAIL stream_count: got %0d expected 8", n_out); end
  endtask

  task automatic test_backpressure;
    int          n_acc, n_out, cyc;
    logic        held;
    beat_t       hold, e;
    logic [31:0] l, r;
    logic [47:0] k;
    logic        last;
    n_acc = 0; held = 1'b0; hold = '0;
    exp_q.delete();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      vec(20 + n_acc, l, r, k, last);
      drive(1'b1, l, r, k, last);
      #1;
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_round(bus.in_l, bus.in_r, bus.in_k, bus.in_last));
        n_acc++;
      end
      if (bus.out_valid) begin
        if (!held) begin hold = {bus.out_l, bus.out_r}; held = 1'b1; end
        else begin
          checks++;
          if ({bus.out_l, bus.out_r} !== hold) begin
            errors++; $display("FAIL stall_hold_c%0d: got %h expected %h", c, {bus.out_l, bus.out_r}, hold);
          end
        end
      end
      @(negedge clk);
    end
    checks++; if (n_acc != STALL_ACCEPTS) begin errors++; $display("FAIL stall_accepts: got %0d expected %0d", n_acc, STALL_ACCEPTS); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b expected 0", bus.in_ready); end
    drive(1'b0, '0, '0, '0, 1'b0);
    bus.out_ready = 1'b1;
    n_out = 0; cyc = 0;
    while (exp_q.size() > 0 && cyc < 20) begin
      #1;
      if (bus.out_valid) begin
        e = exp_q.pop_front();
        checks++;
        if ({bus.out_l, bus.out_r} !== e) begin
          errors++; $display("FAIL stall_drain%0d: got %h expected %h", n_out, {bus.out_l, bus.out_r}, e);
        end
        n_out++;
      end
      @(negedge clk);
      cyc++;
    end
    checks++; if (n_out != STALL_ACCEPTS) begin errors++; $display("FAIL stall_delivered: got %0d expected %0d", n_out, STALL_ACCEPTS); end
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stall_empty: got %b expected 0", bus.out_valid); end
    @(negedge clk);
  endtask

  task automatic test_reset_midflight;
    logic [31:0] l, r;
    logic [47:0] k;
    logic        last;
    exp_q.delete();
    bus.out_ready = 1'b0;
    vec(40, l, r, k, last); drive(1'b1, l, r, k, last);
    @(negedge clk);
    vec(41, l, r, k, last); drive(1'b1, l, r, k, last);
    @(negedge clk);
    drive(1'b0, '0, '0, '0, 1'b0);
    #1;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL midrst_full: got %b expected 1", bus.out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_l !== 32'h0) begin errors++; $display("FAIL midrst_out_l: got %h expected 00000000", bus.out_l); end
    checks++; if (bus.out_r !== 32'h0) begin errors++; $display("FAIL midrst_out_r: got %h expected 00000000", bus.out_r); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_idle_c%0d: got %b expected 0", c, bus.out_valid); end
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    int          n_in, n_out, cyc;
    logic        pend;
    logic [63:0] t;
    beat_t       e;
    n_in = 0; n_out = 0; cyc = 0; pend = 1'b0;
    exp_q.delete();
    drive(1'b0, '0, '0, '0, 1'b0);
    while (n_out < N_RAND && cyc < 60000) begin
      if (!pend && n_in < N_RAND && $urandom_range(0, 99) < 70) begin
        t = {$urandom, $urandom};
        drive(1'b1, $urandom, $urandom, t[47:0], 1'($urandom_range(0, 1)));
        pend = 1'b1;
      end
      bus.out_ready = ($urandom_range(0, 99) < 70);
      #1;
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_round(bus.in_l, bus.in_r, bus.in_k, bus.in_last));
        n_in++;
        pend = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL random_extra: got %h%h expected no beat", bus.out_l, bus.out_r);
        end else begin
          e = exp_q.pop_front();
          if ({bus.out_l, bus.out_r} !== e) begin
            errors++; $display("FAIL random_beat%0d: got %h expected %h", n_out, {bus.out_l, bus.out_r}, e);
          end
        end
        n_out++;
      end
      @(negedge clk);
      if (!pend) bus.in_valid = 1'b0;
      cyc++;
    end
    checks++; if (n_out != N_RAND) begin errors++; $display("FAIL random_count: got %0d expected %0d", n_out, N_RAND); end
  endtask

  initial begin
    test_reset;
    test_round1;
    test_zero;
    test_back_to_back;
    test_backpressure;
    test_reset_midflight;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached with %0d errors of %0d checks", errors, checks);
    $fatal(1, "simulation time limit");
  end

endmodule
